// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared Tomasulo-core constants and the CDB broadcast bundle
//                snooped by reservation stations, register file and dispatcher.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Producer tag width (matches the register-file src field) and result width
    localparam int c_TAG_W  = 15;
    localparam int c_DATA_W = 16;

    // One CDB broadcast as seen by every consumer
    typedef struct packed {
        logic                valid;
        logic [c_TAG_W-1:0]  tag;
        logic [c_DATA_W-1:0] data;
    } cdb_t;

    // Index width able to address n requesters, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_if
//  Description : FU request handshake plus CDB broadcast bundle. The master
//                modport is the FU/consumer side, the slave modport is the
//                arbiter. Optional macro CDB_BUSY_CNT_EN adds the busy counter
//                and its clear input.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 15,
    parameter int DATA_W = 16
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    flush;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
`ifdef CDB_BUSY_CNT_EN
    logic                    cnt_clr;
    logic [15:0]             cdb_busy_cnt;
`endif

    modport master (
`ifdef CDB_BUSY_CNT_EN
        output cnt_clr,
        input  cdb_busy_cnt,
`endif
        output req_valid, req_tag, req_data, flush,
        input  req_ready, cdb_valid, cdb_tag, cdb_data
    );

    modport slave (
`ifdef CDB_BUSY_CNT_EN
        input  cnt_clr,
        output cdb_busy_cnt,
`endif
        input  req_valid, req_tag, req_data, flush,
        output req_ready, cdb_valid, cdb_tag, cdb_data
    );

endinterface : cdb_arbiter_if
`default_nettype wire

// File: rtl/cdb_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin priority finder. Scans requesters
//                starting at ptr (wrapping modulo N_REQ) and reports the first
//                active one as a one-hot grant plus its binary index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    // First active requester at or after ptr, wrapping around the vector
    always_comb begin
        int j;
        logic [PTR_W-1:0] w_j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        w_j   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            w_j = PTR_W'(j);
            if (!any && req[w_j]) begin
                any        = 1'b1;
                grant[w_j] = 1'b1;
                idx        = w_j;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Round-robin arbiter for the common data bus. One FU result is
//                accepted per cycle and broadcast from a register the cycle
//                after acceptance. Flush blocks acceptance without disturbing
//                the pointer. Optional macro CDB_BUSY_CNT_EN adds a saturating
//                count of busy bus cycles with synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cpu_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = c_TAG_W,
    parameter int DATA_W = c_DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    cdb_arbiter_if.slave  bus
);

    localparam int c_PTR_W = idx_w(N_REQ);

    logic [c_PTR_W-1:0] r_rr_ptr;
    logic [c_PTR_W-1:0] w_idx;
    logic [N_REQ-1:0]   w_grant;
    logic               w_any;
    logic               w_accept;
    logic [TAG_W-1:0]   w_sel_tag;
    logic [DATA_W-1:0]  w_sel_data;
    logic               r_cdb_valid;
    logic [TAG_W-1:0]   r_cdb_tag;
    logic [DATA_W-1:0]  r_cdb_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (c_PTR_W)
    ) u_pick (
        .req   (bus.req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    // Reset and flush both hold every grant low so nothing can be accepted
    assign w_accept      = w_any & ~bus.flush & rst_n;
    assign bus.req_ready = w_accept ? w_grant : '0;

    // AND-OR mux of the winner's tag/data driven by the one-hot grant
    always_comb begin
        w_sel_tag  = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_tag  = w_sel_tag  | bus.req_tag[i*TAG_W +: TAG_W];
                w_sel_data = w_sel_data | bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer moves to one past the accepted winner, wrapping at N_REQ-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_idx == c_PTR_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    // Broadcast register: valid for exactly the cycle after acceptance; tag/data hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
        end else begin
            r_cdb_valid <= w_accept;
            if (w_accept) begin
                r_cdb_tag  <= w_sel_tag;
                r_cdb_data <= w_sel_data;
            end
        end
    end

    assign bus.cdb_valid = r_cdb_valid;
    assign bus.cdb_tag   = r_cdb_tag;
    assign bus.cdb_data  = r_cdb_data;

`ifdef CDB_BUSY_CNT_EN
    logic [15:0] r_busy_cnt;

    // Saturating count of cycles with a valid broadcast; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_busy_cnt <= '0;
        end else if (r_cdb_valid && (r_busy_cnt != 16'hFFFF)) begin
            r_busy_cnt <= r_busy_cnt + 16'd1;
        end
    end

    assign bus.cdb_busy_cnt = r_busy_cnt;
`endif

endmodule : cdb_arbiter
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Self-checking bench for cdb_arbiter (N_REQ=4). Directed
//                vector table for grant order, broadcast latency, flush and
//                wrap-around, plus hand sequences for mid-stream reset and,
//                when CDB_BUSY_CNT_EN is defined, the busy counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int N_REQ  = 4;
    localparam int TAG_W  = 15;
    localparam int DATA_W = 16;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    cdb_arbiter_if #(.N_REQ(N_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_bus ();

    cdb_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic        flush;
        logic [15:0] d2;
        logic [3:0]  exp_ready;
        logic        exp_cv;
        logic [14:0] exp_tag;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // FU i presents tag 5+i; FU2 data is variable per vector
    task automatic apply(input logic [3:0] v, input logic fl, input logic [15:0] d2);
        u_bus.req_valid = v;
        u_bus.flush     = fl;
        u_bus.req_tag   = {15'h0008, 15'h0007, 15'h0006, 15'h0005};
        u_bus.req_data  = {16'h3333, d2, 16'h1111, 16'hBEEF};
    endtask

    task automatic chk_bus(input string nm, input logic [3:0] rdy, input logic cv,
                           input logic [14:0] tg, input logic [15:0] dt);
        chk({nm, " ready"}, 32'(u_bus.req_ready), 32'(rdy));
        chk({nm, " cdb_valid"}, 32'(u_bus.cdb_valid), 32'(cv));
        chk({nm, " cdb_tag"}, 32'(u_bus.cdb_tag), 32'(tg));
        chk({nm, " cdb_data"}, 32'(u_bus.cdb_data), 32'(dt));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        // Grant rotation and one-cycle broadcast lag
        vecs[0]  = '{4'b1111, 1'b0, 16'h2222, 4'b0001, 1'b0, 15'h0, 16'h0000};
        vecs[1]  = '{4'b1111, 1'b0, 16'h2222, 4'b0010, 1'b1, 15'h5, 16'hBEEF};
        vecs[2]  = '{4'b1111, 1'b0, 16'h2222, 4'b0100, 1'b1, 15'h6, 16'h1111};
        vecs[3]  = '{4'b1111, 1'b0, 16'h2222, 4'b1000, 1'b1, 15'h7, 16'h2222};
        vecs[4]  = '{4'b1111, 1'b0, 16'h2222, 4'b0001, 1'b1, 15'h8, 16'h3333};
        vecs[5]  = '{4'b1111, 1'b0, 16'h2222, 4'b0010, 1'b1, 15'h5, 16'hBEEF};
        vecs[6]  = '{4'b1111, 1'b0, 16'h2222, 4'b0100, 1'b1, 15'h6, 16'h1111};
        vecs[7]  = '{4'b1111, 1'b0, 16'h2222, 4'b1000, 1'b1, 15'h7, 16'h2222};
        // Idle, then FU2 alone with three back-to-back results
        vecs[8]  = '{4'b0000, 1'b0, 16'h2222, 4'b0000, 1'b1, 15'h8, 16'h3333};
        vecs[9]  = '{4'b0100, 1'b0, 16'h0001, 4'b0100, 1'b0, 15'h8, 16'h3333};
        vecs[10] = '{4'b0100, 1'b0, 16'h0002, 4'b0100, 1'b1, 15'h7, 16'h0001};
        vecs[11] = '{4'b0100, 1'b0, 16'h0003, 4'b0100, 1'b1, 15'h7, 16'h0002};
        // Pointer at 3: FU3 then FU0 (wrap)
        vecs[12] = '{4'b1001, 1'b0, 16'h0003, 4'b1000, 1'b1, 15'h7, 16'h0003};
        vecs[13] = '{4'b1001, 1'b0, 16'h0003, 4'b0001, 1'b1, 15'h8, 16'h3333};
        // Flush blocks grant but the registered broadcast completes
        vecs[14] = '{4'b0100, 1'b1, 16'h0003, 4'b0000, 1'b1, 15'h5, 16'hBEEF};
        vecs[15] = '{4'b0100, 1'b0, 16'h00AA, 4'b0100, 1'b0, 15'h5, 16'hBEEF};
        vecs[16] = '{4'b0000, 1'b0, 16'h00AA, 4'b0000, 1'b1, 15'h7, 16'h00AA};
        vecs[17] = '{4'b0000, 1'b0, 16'h00AA, 4'b0000, 1'b0, 15'h7, 16'h00AA};

        rst_n = 1'b0;
        apply(4'b1111, 1'b0, 16'h2222);
`ifdef CDB_BUSY_CNT_EN
        u_bus.cnt_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk_bus("in_reset", 4'b0000, 1'b0, 15'h0, 16'h0000);
`ifdef CDB_BUSY_CNT_EN
        chk("in_reset busy_cnt", 32'(u_bus.cdb_busy_cnt), 32'h0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge clk);
            apply(vecs[i].valid, vecs[i].flush, vecs[i].d2);
            #1;
            chk_bus($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_cv,
                    vecs[i].exp_tag, vecs[i].exp_data);
        end

        // Mid-stream asynchronous reset while a broadcast is on the bus
        @(negedge clk);
        apply(4'b1111, 1'b0, 16'h00AA);
        #1;
        chk_bus("mrst pre0", 4'b1000, 1'b0, 15'h7, 16'h00AA);
        @(negedge clk);
        #1;
        chk_bus("mrst pre1", 4'b0001, 1'b1, 15'h8, 16'h3333);
        @(posedge clk);
        #1;
        chk("mrst live cdb_valid", 32'(u_bus.cdb_valid), 32'h1);
        chk("mrst live cdb_tag", 32'(u_bus.cdb_tag), 32'h5);
        #1;
        rst_n = 1'b0;
        #1;
        chk_bus("mrst asserted", 4'b0000, 1'b0, 15'h0, 16'h0000);
`ifdef CDB_BUSY_CNT_EN
        chk("mrst busy_cnt", 32'(u_bus.cdb_busy_cnt), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst ptr_zero ready", 32'(u_bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("mrst first cdb_valid", 32'(u_bus.cdb_valid), 32'h1);
        chk("mrst first cdb_data", 32'(u_bus.cdb_data), 32'hBEEF);

`ifdef CDB_BUSY_CNT_EN
        // Continuous traffic: clear, count, then saturate
        @(negedge clk);
        u_bus.cnt_clr = 1'b1;
        @(negedge clk);
        u_bus.cnt_clr = 1'b0;
        #1;
        chk("cnt after clr", 32'(u_bus.cdb_busy_cnt), 32'h0);
        repeat (5) @(negedge clk);
        #1;
        chk("cnt after 5", 32'(u_bus.cdb_busy_cnt), 32'h5);
        repeat (65540) @(negedge clk);
        #1;
        chk("cnt saturated", 32'(u_bus.cdb_busy_cnt), 32'hFFFF);
        @(negedge clk);
        u_bus.cnt_clr = 1'b1;
        @(negedge clk);
        u_bus.cnt_clr = 1'b0;
        #1;
        chk("cnt clr from sat", 32'(u_bus.cdb_busy_cnt), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cdb_arbiter
`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single common data bus (CDB) between functional units (FUs) that have finished an instruction and hold a result for broadcast.
- Picks one FU per cycle using round-robin and drives a registered tag/value broadcast.
- Reservation stations, the register file and the dispatcher snoop that broadcast.
- Sits between the FU outputs and all CDB consumers in the Tomasulo core.

Parameters:
- N_REQ, 4, number of requesting FUs (2..8).
- TAG_W, 15, width of the producer tag; matches the register-file src field.
- DATA_W, 16, width of the result value.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  FU i holds a result for broadcast.
- req_tag  input  N_REQ*TAG_W  tag of FU i's result, packed as slice [i*TAG_W +: TAG_W].
- req_data  input  N_REQ*DATA_W  value of FU i's result, packed as slice [i*DATA_W +: DATA_W].
- req_ready  output  N_REQ  one-hot grant; FU i's result is accepted this cycle.
- flush  input  1  mispredict flush; squashes arbitration and any pending broadcast.
- cdb_valid  output  1  broadcast valid.
- cdb_tag  output  TAG_W  broadcast tag.
- cdb_data  output  DATA_W  broadcast value.

Behaviour:
- Reset is asynchronous on rst_n low:
  - cdb_valid=0, cdb_tag=0, cdb_data=0.
  - rr_ptr=0.
  - req_ready reads 0 while rst_n is low.
- Reset asserted mid-operation drops any in-flight broadcast. The FU must re-present its result after reset.
- Handshake:
  - An FU asserts req_valid and holds tag/data stable until it sees req_ready high in the same cycle.
  - Acceptance happens at the rising edge where req_valid[i] && req_ready[i].
  - The FU may deassert req_valid, or present a new result, in the following cycle.
- req_ready is combinational from req_valid, rr_ptr and flush. It is at most one-hot and never high for a non-valid requester.
- Arbitration:
  - Scan i = rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - The first valid requester is the winner.
  - If there is a winner, rr_ptr <= (winner+1) mod N_REQ. Otherwise rr_ptr is unchanged.
- Latency:
  - The winner accepted at edge k drives cdb_valid/tag/data during cycle k+1, for exactly one cycle.
  - There is no back-pressure from consumers; the CDB always sinks.
  - Throughput is one broadcast per cycle. Back-to-back grants are allowed, including to the same FU if it is the only requester.
- If no requester is valid, cdb_valid=0 on the next cycle. cdb_tag/cdb_data hold their last values and are don't-care for consumers.
- Flush:
  - When flush=1, req_ready=0 for all requesters and nothing is accepted.
  - Next cycle cdb_valid=0, even if a grant would otherwise have occurred.
  - rr_ptr is unchanged.
  - A broadcast already on the bus in the flush cycle completes, because it was registered earlier.
- Fairness: with all N_REQ requesting continuously, each FU is granted exactly once every N_REQ cycles.
- Wrap-around: rr_ptr = N_REQ-1 with a winner at N_REQ-1 gives rr_ptr=0.

Optional Feature:
- CDB_BUSY_CNT_EN defined:
  - Adds output cdb_busy_cnt [15:0] and input cnt_clr [1].
  - The counter increments on every cycle cdb_valid=1 and saturates at 16'hFFFF.
  - cnt_clr=1 synchronously zeroes it, taking priority over increment.
  - rst_n low clears it asynchronously.
- Undefined: neither port exists and there are no counter flops.

Decomposition:
- Shared package (cpu_pkg):
  - TAG_W and DATA_W constants.
  - The CDB bundle typedef {valid, tag[TAG_W], data[DATA_W]}, reused by reservation stations and the register file.
- One sub-module, rr_pick: combinational round-robin priority finder.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, winner index, any.
- The arbiter wraps rr_pick with the pointer register, flush gating and the broadcast register.

Test Plan:
- Reset with req_valid=4'b1111, then release -> first grant req_ready=4'b0001; next cycle cdb_valid=1 with FU0's tag/data (tag 15'h0005, data 16'hBEEF).
- All four requesting continuously for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3; cdb_tag follows each with a one-cycle lag.
- Only FU2 valid for 3 consecutive results (data 1,2,3) -> three back-to-back grants; cdb_data=1,2,3 on consecutive cycles.
- rr_ptr=3, req_valid=4'b1001 -> grant FU3, then FU0; rr_ptr wraps 3->0->1.
- req_valid=4'b0100 with flush=1 -> req_ready=0, next cycle cdb_valid=0; flush=0 the following cycle -> FU2 granted, broadcast one cycle later.
- Pulse rst_n low mid-stream while cdb_valid=1 -> cdb_valid drops to 0 immediately (asynchronous) and rr_ptr=0; with CDB_BUSY_CNT_EN, the counter reads 0 and saturates at 16'hFFFF under a forced long run.
